// File: rtl/proc_pkg.sv
// Shared definitions for the 10-bit processor control path:
// opcode / ALU function codes, step encoding, instruction field positions.
package proc_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_LOAD = 4'd0;
  localparam logic [OPC_W-1:0] OP_COPY = 4'd1;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OPC_W-1:0] OP_INV  = 4'd4;
  localparam logic [OPC_W-1:0] OP_FLIP = 4'd5;
  localparam logic [OPC_W-1:0] OP_AND  = 4'd6;
  localparam logic [OPC_W-1:0] OP_OR   = 4'd7;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'd8;
  localparam logic [OPC_W-1:0] OP_LSL  = 4'd9;
  localparam logic [OPC_W-1:0] OP_LSR  = 4'd10;
  localparam logic [OPC_W-1:0] OP_ASR  = 4'd11;

  typedef enum logic [1:0] {T0, T1, T2, T3} t_step_e;

  // Instruction fields: Rx = IR[9:8], Ry = IR[7:6], IR[5:4] unused, op = IR[3:0]
  localparam int unsigned RX_MSB = 9;
  localparam int unsigned RX_LSB = 8;
  localparam int unsigned RY_MSB = 7;
  localparam int unsigned RY_LSB = 6;
  localparam int unsigned UN_MSB = 5;
  localparam int unsigned UN_LSB = 4;
  localparam int unsigned OP_MSB = 3;
  localparam int unsigned OP_LSB = 0;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_ASR);
  endfunction

  function automatic logic is_unary_op(input logic [OPC_W-1:0] op);
    return (op == OP_INV) || (op == OP_FLIP);
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot decoder with enable.
//   en     : enable; output is all-zero when low
//   idx    : register index
//   onehot : one-hot select, N_REGS wide
module reg_onehot_dec #(
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned N_REGS = 4
) (
  input  logic              en,
  input  logic [IDX_W-1:0]  idx,
  output logic [N_REGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (en && (idx == IDX_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/proc_controller.sv
// Multi-cycle control FSM for the 10-bit processor (T0..T3).
//   clk, rst      : clock, async active-high reset
//   exec, clr     : start request (T0 only), synchronous abort
//   instr         : instruction word captured into IR on IRin
//   IRin          : IR load strobe
//   Rin, Rout     : one-hot register write enable / bus drive
//   Extern, Gout  : external data / ALU result bus drive
//   Ain, Gin      : ALU A / G register loads
//   ALUcont       : ALU function code (T2 only)
//   Done, busy    : retire pulse, not-in-T0 flag
module proc_controller
  import proc_pkg::*;
#(
  parameter int unsigned WORD_W = 10,
  parameter int unsigned N_REGS = 4,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exec,
  input  logic              clr,
  input  logic [WORD_W-1:0] instr,
  output logic              IRin,
  output logic [N_REGS-1:0] Rin,
  output logic [N_REGS-1:0] Rout,
  output logic              Extern,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [OP_W-1:0]   ALUcont,
  output logic              Done,
  output logic              busy
);

  t_step_e           step_q, step_d;
  logic [WORD_W-1:0] ir_q, ir_d;

  logic [IDX_W-1:0]  rx, ry;
  logic [OP_W-1:0]   op;
  logic              ir_unused;

  logic              rin_en, rout_en;
  logic [IDX_W-1:0]  rin_idx, rout_idx;

  assign rx        = ir_q[RX_MSB:RX_LSB];
  assign ry        = ir_q[RY_MSB:RY_LSB];
  assign op        = ir_q[OP_MSB:OP_LSB];
  assign ir_unused = ^ir_q[UN_MSB:UN_LSB];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    ir_d     = ir_q;
    IRin     = 1'b0;
    Extern   = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    ALUcont  = '0;
    Done     = 1'b0;
    rin_en   = 1'b0;
    rin_idx  = rx;
    rout_en  = 1'b0;
    rout_idx = rx;

    case (step_q)
      T0: begin
        // rst only forces the state; IRin also needs gating while rst is high
        IRin = exec & ~clr & ~rst;
        if (IRin) begin
          ir_d   = instr;
          step_d = T1;
        end
      end
      T1: begin
        if (op == OP_LOAD) begin
          Extern = 1'b1;
          rin_en = 1'b1;
          Done   = 1'b1;
          step_d = T0;
        end else if (op == OP_COPY) begin
          rout_en  = 1'b1;
          rout_idx = ry;
          rin_en   = 1'b1;
          Done     = 1'b1;
          step_d   = T0;
        end else if (is_alu_op(op)) begin
          rout_en = 1'b1;
          Ain     = 1'b1;
          step_d  = T2;
        end else begin
          Done   = 1'b1;
          step_d = T0;
        end
      end
      T2: begin
        ALUcont  = op;
        Gin      = 1'b1;
        rout_en  = ~is_unary_op(op);
        rout_idx = ry;
        step_d   = T3;
      end
      T3: begin
        Gout   = ~clr;
        rin_en = ~clr;
        Done   = 1'b1;
        step_d = T0;
      end
      default: step_d = T0;
    endcase

    if (clr) begin
      step_d = T0;
      Done   = 1'b0;
    end
  end

  assign busy = (step_q != T0);

  reg_onehot_dec #(
    .IDX_W  (IDX_W),
    .N_REGS (N_REGS)
  ) u_rin_dec (
    .en     (rin_en),
    .idx    (rin_idx),
    .onehot (Rin)
  );

  reg_onehot_dec #(
    .IDX_W  (IDX_W),
    .N_REGS (N_REGS)
  ) u_rout_dec (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_proc_controller.sv
module tb_proc_controller;

  logic       clk;
  logic       rst;
  logic       exec;
  logic       clr;
  logic [9:0] instr;
  logic       IRin;
  logic [3:0] Rin;
  logic [3:0] Rout;
  logic       Extern;
  logic       Ain;
  logic       Gin;
  logic       Gout;
  logic [3:0] ALUcont;
  logic       Done;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  proc_controller #(
    .WORD_W (10),
    .N_REGS (4),
    .IDX_W  (2),
    .OP_W   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .exec    (exec),
    .clr     (clr),
    .instr   (instr),
    .IRin    (IRin),
    .Rin     (Rin),
    .Rout    (Rout),
    .Extern  (Extern),
    .Ain     (Ain),
    .Gin     (Gin),
    .Gout    (Gout),
    .ALUcont (ALUcont),
    .Done    (Done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packed output vector: {IRin,Rin,Rout,Extern,Ain,Gin,Gout,ALUcont,Done,busy}
  function automatic logic [18:0] ov(input logic irin, input logic [3:0] rin,
                                     input logic [3:0] rout, input logic ext,
                                     input logic ain, input logic gin, input logic gout,
                                     input logic [3:0] alu, input logic done,
                                     input logic bsy);
    return {irin, rin, rout, ext, ain, gin, gout, alu, done, bsy};
  endfunction

  function automatic logic [18:0] outs();
    return {IRin, Rin, Rout, Extern, Ain, Gin, Gout, ALUcont, Done, busy};
  endfunction

  // One cycle: drive inputs after the falling edge, check settled outputs before the rising edge
  task automatic cyc(input logic e, input logic c, input logic [9:0] i,
                     input logic [18:0] exp, input string tag);
    @(negedge clk);
    exec  = e;
    clr   = c;
    instr = i;
    #1;
    check(tag, 32'(outs()), 32'(exp));
  endtask

  localparam logic [18:0] IDLE = 19'd0;

  initial begin
    rst   = 1'b1;
    exec  = 1'b1;
    clr   = 1'b0;
    instr = 10'h300;

    // Reset held with exec high: everything quiet, IRin included
    cyc(1, 0, 10'h300, IDLE, "rst_hold");
    exec = 1'b0;
    rst  = 1'b0;

    // LOAD R3
    cyc(1, 0, 10'h300, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "load_t0");
    cyc(0, 0, 10'h000, ov(0, 4'b1000, 4'b0000, 1, 0, 0, 0, 4'd0, 1, 1), "load_t1");
    cyc(0, 0, 10'h000, IDLE, "load_idle");

    // COPY R0 <- R3
    cyc(1, 0, 10'h0C1, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "copy_t0");
    cyc(0, 0, 10'h000, ov(0, 4'b0001, 4'b1000, 0, 0, 0, 0, 4'd0, 1, 1), "copy_t1");
    cyc(0, 0, 10'h000, IDLE, "copy_idle");

    // ADD R1,R2
    cyc(1, 0, 10'h182, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "add_t0");
    cyc(0, 0, 10'h000, ov(0, 4'b0000, 4'b0010, 0, 1, 0, 0, 4'd0, 0, 1), "add_t1");
    cyc(0, 0, 10'h000, ov(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 4'd2, 0, 1), "add_t2");
    cyc(0, 0, 10'h000, ov(0, 4'b0010, 4'b0000, 0, 0, 0, 1, 4'd0, 1, 1), "add_t3");
    cyc(0, 0, 10'h000, IDLE, "add_idle");

    // INV R2 (unary: no Rout in T2)
    cyc(1, 0, 10'h204, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "inv_t0");
    cyc(0, 0, 10'h000, ov(0, 4'b0000, 4'b0100, 0, 1, 0, 0, 4'd0, 0, 1), "inv_t1");
    cyc(0, 0, 10'h000, ov(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 4'd4, 0, 1), "inv_t2");
    cyc(0, 0, 10'h000, ov(0, 4'b0100, 4'b0000, 0, 0, 0, 1, 4'd0, 1, 1), "inv_t3");

    // Reserved opcode 15: NOP with Done
    cyc(1, 0, 10'h00F, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "rsv_t0");
    cyc(0, 0, 10'h000, ov(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 1, 1), "rsv_t1");
    cyc(0, 0, 10'h000, IDLE, "rsv_idle");

    // clr in T2 of ADD, exec held: immediate refetch of LOAD R3
    cyc(1, 0, 10'h182, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "clr2_t0");
    cyc(1, 0, 10'h182, ov(0, 4'b0000, 4'b0010, 0, 1, 0, 0, 4'd0, 0, 1), "clr2_t1");
    cyc(1, 1, 10'h182, ov(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 4'd2, 0, 1), "clr2_t2");
    cyc(1, 0, 10'h300, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "clr2_refetch");
    cyc(0, 0, 10'h000, ov(0, 4'b1000, 4'b0000, 1, 0, 0, 0, 4'd0, 1, 1), "clr2_load_t1");

    // clr with exec in T0: no fetch
    cyc(1, 1, 10'h300, IDLE, "clr_t0");
    cyc(0, 0, 10'h000, IDLE, "clr_t0_nofetch");

    // clr in T3: write and Done suppressed
    cyc(1, 0, 10'h182, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "clr3_t0");
    cyc(0, 0, 10'h000, ov(0, 4'b0000, 4'b0010, 0, 1, 0, 0, 4'd0, 0, 1), "clr3_t1");
    cyc(0, 0, 10'h000, ov(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 4'd2, 0, 1), "clr3_t2");
    cyc(0, 1, 10'h000, ov(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 1), "clr3_t3");
    cyc(0, 0, 10'h000, IDLE, "clr3_idle");

    // Back-to-back with exec held: Done at cycles 2 and 6
    cyc(1, 0, 10'h300, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "b2b_c1");
    cyc(1, 0, 10'h182, ov(0, 4'b1000, 4'b0000, 1, 0, 0, 0, 4'd0, 1, 1), "b2b_c2");
    cyc(1, 0, 10'h182, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "b2b_c3");
    cyc(1, 0, 10'h300, ov(0, 4'b0000, 4'b0010, 0, 1, 0, 0, 4'd0, 0, 1), "b2b_c4");
    cyc(1, 0, 10'h300, ov(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 4'd2, 0, 1), "b2b_c5");
    cyc(0, 0, 10'h000, ov(0, 4'b0010, 4'b0000, 0, 0, 0, 1, 4'd0, 1, 1), "b2b_c6");
    cyc(0, 0, 10'h000, IDLE, "b2b_idle");

    // Async reset mid-T3: outputs drop before the next rising edge, no Done, IR cleared
    cyc(1, 0, 10'h182, ov(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 4'd0, 0, 0), "arst_t0");
    cyc(0, 0, 10'h000, ov(0, 4'b0000, 4'b0010, 0, 1, 0, 0, 4'd0, 0, 1), "arst_t1");
    cyc(0, 0, 10'h000, ov(0, 4'b0000, 4'b0100, 0, 0, 1, 0, 4'd2, 0, 1), "arst_t2");
    cyc(1, 0, 10'h000, ov(0, 4'b0010, 4'b0000, 0, 0, 0, 1, 4'd0, 1, 1), "arst_t3");
    #2;
    rst = 1'b1;
    #1;
    check("arst_outs", 32'(outs()), 32'(IDLE));
    check("arst_ir", 32'(dut.ir_q), 32'h0);
    @(negedge clk);
    #1;
    check("arst_hold_outs", 32'(outs()), 32'(IDLE));
    exec = 1'b0;
    rst  = 1'b0;
    cyc(0, 0, 10'h000, IDLE, "arst_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
